// File: rtl/shift_add_mult16.sv
// Sequential unsigned shift-add multiplier: WIDTH add/shift steps per operand pair, valid/ready in and out.
// Optional MULT_ZERO_SKIP_EN: a zero operand bypasses CALC and produces 0 one edge after acceptance.
module shift_add_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid stays high with product stable until out_ready.
    logic [1:0]          state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    plier;
    logic                carry;
    logic [CW-1:0]       count;
    logic [2*WIDTH-1:0]  product_q;
    logic                out_valid_q;

    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    acc_next;
    logic [WIDTH-1:0]    plier_next;
    logic                zero_op;

    // The add keeps its carry-out in sum[WIDTH]; the shift moves it into the acc MSB.
    always_comb begin
        sum        = {1'b0, acc} + {{WIDTH{1'b0}}, carry};
        if (plier[0]) begin
            sum = sum + {1'b0, mcand};
        end
        acc_next   = sum[WIDTH:1];
        plier_next = {sum[0], plier[WIDTH-1:1]};
    end

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mcand       <= '0;
            acc         <= '0;
            plier       <= '0;
            carry       <= 1'b0;
            count       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        acc   <= '0;
                        carry <= 1'b0;
                        plier <= b;
                        count <= '0;
                        if (zero_op) begin
                            product_q   <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    plier <= plier_next;
                    carry <= 1'b0;
                    count <= count + CW'(1);
                    // Last step registers the product directly so out_valid rises with it.
                    if (count == CW'(WIDTH - 1)) begin
                        product_q   <= {acc_next, plier_next};
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CALC);
    assign out_valid = out_valid_q;
    assign product   = product_q;
endmodule

// File: tb/tb_shift_add_mult16.sv
// Directed bench for shift_add_mult16: reset, multiplies, latency, backpressure, mid-op reset, zero operand.
module tb_shift_add_mult16;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_add_mult16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair, then counts edges (accept edge = 1) until out_valid and busy cycles seen.
    task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv,
                                  output int lat, output int busy_cnt);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 16'hxxxx;
        b        = 16'hxxxx;
        lat      = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
    endtask

    task automatic run_mult(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic [31:0] exp_p, input int exp_lat);
        int lat;
        int bc;
        out_ready = 1'b1;
        start_and_wait(av, bv, lat, bc);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
        check({tag, "_product"}, 64'(product), 64'(exp_p));
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        step();
        check({tag, "_out_valid_clear"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int bc;
        logic [31:0] held;
        int zero_lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) step();
        check("rst_product", 64'(product), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_in_ready", 64'(in_ready), 64'd1);
            check("idle_out_valid", 64'(out_valid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end

        run_mult("basic", 16'h0003, 16'h0005, 32'h0000000F, 17);
        run_mult("carry", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
        run_mult("shift", 16'h1234, 16'h0010, 32'h00012340, 17);
        run_mult("byte", 16'h00FF, 16'h0100, 32'h0000FF00, 17);
        run_mult("ident", 16'hABCD, 16'h0001, 32'h0000ABCD, 17);
        run_mult("msb", 16'h8001, 16'h8001, 32'h40010001, 17);

        // Backpressure with in_valid offered during the wait.
        out_ready = 1'b0;
        start_and_wait(16'h8000, 16'h0002, lat, bc);
        check("bp_latency", 64'(lat), 64'd17);
        check("bp_product", 64'(product), 64'h00010000);
        held = 32'h00010000;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 16'h0007;
            b        = 16'h0009;
            step();
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_product_hold", 64'(product), 64'(held));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_busy_low", 64'(busy), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_busy", 64'(busy), 64'd0);

        // Reset five cycles into CALC.
        a        = 16'h0003;
        b        = 16'h0005;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("midop_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midop_busy", 64'(busy), 64'd0);
        check("midop_in_ready", 64'(in_ready), 64'd1);
        check("midop_out_valid", 64'(out_valid), 64'd0);
        check("midop_product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("midop_idle_after", 64'(in_ready), 64'd1);

`ifdef MULT_ZERO_SKIP_EN
        zero_lat = 1;
`else
        zero_lat = 17;
`endif
        run_mult("zero_a", 16'h0000, 16'h1234, 32'h00000000, zero_lat);
        run_mult("after_zero", 16'h0002, 16'h0003, 32'h00000006, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
